// File: rtl/microinstr_pipe.sv
// Microinstruction decode pipeline: DEPTH register stages carrying a ROM word and its data
// address, with per-stage valid, stall/flush control, busy flag and saturating retire counter.
module microinstr_pipe #(
    parameter int ALU_W  = 4,
    parameter int SH_W   = 2,
    parameter int M_W    = 2,
    parameter int B_W    = 6,
    parameter int C_W    = 6,
    parameter int T_W    = 7,
    parameter int A_W    = 5,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16,
    localparam int MI_W  = ALU_W + SH_W + 1 + M_W + B_W + C_W + T_W + A_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [MI_W-1:0]   micro_instr_ROM,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] data_address_in,
    input  logic              stall,
    input  logic              flush,
    output logic [ALU_W-1:0]  alu,
    output logic [SH_W-1:0]   shifter,
    output logic              KMx,
    output logic [M_W-1:0]    M,
    output logic [B_W-1:0]    B,
    output logic [C_W-1:0]    C,
    output logic [T_W-1:0]    T,
    output logic [A_W-1:0]    A,
    output logic [ADDR_W-1:0] data_address_out,
    output logic              valid_out,
    output logic              busy,
    output logic [CNT_W-1:0]  retired_count
);

    localparam int T_LSB   = A_W;
    localparam int C_LSB   = T_LSB + T_W;
    localparam int B_LSB   = C_LSB + C_W;
    localparam int M_LSB   = B_LSB + B_W;
    localparam int K_BIT   = M_LSB + M_W;
    localparam int SH_LSB  = K_BIT + 1;
    localparam int ALU_LSB = SH_LSB + SH_W;

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("microinstr_pipe: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]  v_r;
    logic [MI_W-1:0]   instr_r [DEPTH];
    logic [ADDR_W-1:0] addr_r  [DEPTH];
    logic [CNT_W-1:0]  count_r;
    logic              retire_s;

    // Stage registers: flush zeroes everything, stall holds, otherwise shift by one stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_r[i] <= {MI_W{1'b0}};
                addr_r[i]  <= {ADDR_W{1'b0}};
            end
        end else if (flush) begin
            v_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_r[i] <= {MI_W{1'b0}};
                addr_r[i]  <= {ADDR_W{1'b0}};
            end
        end else if (!stall) begin
            // Invalid slots are stored as all-zero so downstream sees NOP fields.
            v_r[0]     <= valid_in;
            instr_r[0] <= valid_in ? micro_instr_ROM : {MI_W{1'b0}};
            addr_r[0]  <= valid_in ? data_address_in : {ADDR_W{1'b0}};
            for (int i = 1; i < DEPTH; i++) begin
                v_r[i]     <= v_r[i-1];
                instr_r[i] <= instr_r[i-1];
                addr_r[i]  <= addr_r[i-1];
            end
        end
    end

    // An instruction retires when it sits in the final stage on a non-stalled edge.
    always_comb begin
        retire_s = v_r[DEPTH-1] & ~stall;
    end

    // Saturating retired-instruction counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (retire_s && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign alu              = instr_r[DEPTH-1][ALU_LSB +: ALU_W];
    assign shifter          = instr_r[DEPTH-1][SH_LSB +: SH_W];
    assign KMx              = instr_r[DEPTH-1][K_BIT];
    assign M                = instr_r[DEPTH-1][M_LSB +: M_W];
    assign B                = instr_r[DEPTH-1][B_LSB +: B_W];
    assign C                = instr_r[DEPTH-1][C_LSB +: C_W];
    assign T                = instr_r[DEPTH-1][T_LSB +: T_W];
    assign A                = instr_r[DEPTH-1][A_W-1:0];
    assign data_address_out = addr_r[DEPTH-1];
    assign valid_out        = v_r[DEPTH-1];
    assign busy             = |v_r;
    assign retired_count    = count_r;

endmodule

// File: doc/microinstr_pipe.md
Name: microinstr_pipe

Overview:
- Parametrised successor of the single-stage microinstruction decode register.
- Splits a ROM microinstruction word into the control fields alu, shifter, KMx, M, B, C, T and A, and carries the associated data address alongside it.
- Field widths and pipeline depth (DEPTH register stages) are configurable.
- Adds a valid bit per stage, stall (hold) and flush (bubble insertion) control, a busy flag and a saturating retired-instruction counter.
- Sits between the microprogram ROM and the datapath control inputs.

Parameters:
ALU_W, 4, alu field width
SH_W, 2, shifter field width
M_W, 2, M field width
B_W, 6, B field width
C_W, 6, C field width
T_W, 7, T field width
A_W, 5, A field width
ADDR_W, 11, data address width
DEPTH, 1, number of register stages (legal range 1..4)
CNT_W, 16, retired counter width
Derived: MI_W = ALU_W+SH_W+1+M_W+B_W+C_W+T_W+A_W (33 at defaults).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
micro_instr_ROM  in  MI_W  microinstruction word
valid_in  in  1  micro_instr_ROM/data_address_in hold a real instruction
data_address_in  in  ADDR_W  data address tied to the instruction
stall  in  1  hold all stages
flush  in  1  kill all in-flight instructions
alu  out  ALU_W  decoded field, final stage
shifter  out  SH_W  decoded field
KMx  out  1  decoded field
M  out  M_W  decoded field
B  out  B_W  decoded field
C  out  C_W  decoded field
T  out  T_W  decoded field
A  out  A_W  decoded field
data_address_out  out  ADDR_W  address from final stage
valid_out  out  1  final stage holds a valid instruction
busy  out  1  OR of all stage valid bits (combinational from registers)
retired_count  out  CNT_W  saturating count of accepted instructions

Behaviour:
Field map, MSB first:
- alu = [MI_W-1 -: ALU_W], then shifter, KMx, M, B, C, T; A = [A_W-1:0].
- Defaults: alu [32:29], shifter [28:27], KMx [26], M [25:24], B [23:18], C [17:12], T [11:5], A [4:0].

Reset:
- reset_n low asynchronously clears every stage's valid bit and payload, and retired_count.
- All outputs read 0 while reset_n is low and until the first valid instruction reaches the final stage.

Stage register content:
- Each stage s[i] holds {v, instr, addr}.
- On capture into s[0], if valid_in=0 the stored instr and addr are all-zero, so invalid slots always present all-zero fields (NOP).

Per rising edge, priority flush > stall > advance:
- flush=1: all v cleared, all payloads zeroed. The current input is dropped even if valid_in=1.
- else stall=1: all stages hold; the input is not captured.
- else advance: s[0] takes the input; s[i] takes s[i-1] for i=1..DEPTH-1.

Latency and outputs:
- Latency from capture to outputs is DEPTH cycles.
- Outputs are driven directly from s[DEPTH-1] registers; there is no combinational path from inputs to outputs.

retired_count:
- Increments by 1 on an edge where valid_out=1 and stall=0, including when flush=1 (the instruction was presented, then accepted).
- Saturates at 2^CNT_W-1 and holds.

Boundary conditions:
- stall held for N cycles: outputs constant, count unchanged.
- Bubbles: valid_in=0 gaps propagate as zero-payload invalid slots.
- Deassertion of reset_n is synchronous to clock by system design. The block has no internal synchronizer.
- Reset mid-stream: all in-flight instructions are discarded, with no partial output.
- DEPTH outside 1..4: elaboration error via a generate-time check.

Test Plan:
1. Decode, DEPTH=1: reset, then drive micro_instr_ROM=33'h1_2345_6789, addr=11'h2A5, valid_in=1 for one cycle. After 1 edge: alu=9, shifter=0, KMx=0, M=3, B=17, C=22, T=60, A=9, data_address_out=11'h2A5, valid_out=1. Next edge: all outputs 0, valid_out=0, retired_count=1.
2. Latency, DEPTH=3: stream 5 valid instructions with addresses 1..5 back-to-back. Address 1 appears after exactly 3 edges, addresses follow in order with no gaps, busy=1 throughout, retired_count=5 after drain.
3. Stall, DEPTH=2: hold stall=1 for 4 cycles while valid_in=1 with new data. Outputs and retired_count are frozen. Data presented during the stall is not captured. After release, the pipeline resumes with the next presented input.
4. Flush: with 2 valid instructions in flight (DEPTH=2) and valid_in=1, assert flush together with stall=1 for one edge. Afterwards all v=0, outputs 0 and busy=0. retired_count is incremented only if valid_out=1 and stall=0 on that edge; here stall=1, so it is unchanged.
5. Reset mid-operation: assert reset_n=0 asynchronously between edges. Outputs go to 0 immediately without a clock. After release, valid_out stays 0 until new input has passed through DEPTH stages.
6. Saturation, CNT_W=3: retire 10 valid instructions. retired_count reads 7 and holds.
